// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between ifetch_unit and imem.
// master = fetch unit, slave = instruction memory.
interface ifetch_unit_if #(
  parameter int ADDR_W = 14
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// MIPS instruction fetch stage: PC, imem handshake, next-PC select.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned jr halts fetch, sets AddrErr.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         Branch,
  input  logic         nBranch,
  input  logic         Jmp,
  input  logic         Jal,
  input  logic         Jr,
  input  logic         Zero,
  input  logic [31:0]  Imme,
  input  logic [31:0]  Jr_target,
  input  logic         Stall,
  ifetch_unit_if.master imem,
  output logic [31:0]  Instruction,
  output logic         Inst_valid,
  output logic [4:0]   Rs,
  output logic [4:0]   Rt,
  output logic [4:0]   Rd,
  output logic [31:0]  PC,
  output logic [31:0]  PC_plus_4,
  output logic         AddrErr
);

  typedef enum logic [1:0] {
    S_RST,
    S_FETCH,
    S_VALID,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4;
  logic [31:0] jr_tgt;
  logic [31:0] npc;
  logic        taken;
  logic        req;
  logic        valid;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic        err_q, err_d;
  logic        misalign;

  assign jr_tgt   = Jr_target;
  assign misalign = Jr && (Jr_target[1:0] != 2'b00);
  assign AddrErr  = err_q;
`else
  assign jr_tgt   = Jr_target & ~32'h3;
  assign AddrErr  = 1'b0;
`endif

  assign pc4   = pc_q + 32'd4;
  assign taken = (Branch & Zero) | (nBranch & ~Zero);

  always_comb begin
    npc = pc4;
    if (Jr)
      npc = jr_tgt;
    else if (Jmp || Jal)
      npc = {pc4[31:28], instr_q[25:0], 2'b00};
    else if (taken)
      npc = pc4 + (Imme << 2);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req     = 1'b0;
    valid   = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        valid = 1'b1;
        if (!Stall) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (misalign) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = npc;
            state_d = S_FETCH;
          end
`else
          pc_d    = npc;
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q[ADDR_W+1:2];

  assign Instruction = instr_q;
  assign Inst_valid  = valid;
  assign Rs          = instr_q[25:21];
  assign Rt          = instr_q[20:16];
  assign Rd          = instr_q[15:11];
  assign PC          = pc_q;
  assign PC_plus_4   = pc4;

endmodule
